// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: oversamples PCLK/VSYNC/HREF/D in the system clock domain,
// pairs bytes into RGB565 pixels and emits a linear frame-buffer write stream.
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_done,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              line_err,
  output logic              ovf_err
);

  localparam int CAP = H_PIXELS * V_LINES;
  // One bit of headroom so the address can sit at CAP even when CAP == 2**ADDR_W.
  localparam int CW  = ADDR_W + 1;
  localparam int LW  = $clog2(H_PIXELS + 2) + 1;

  typedef enum logic [1:0] {WAIT_CFG, SYNC, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [2:0]    pclk_s, vsync_s, href_s;
  logic [7:0]    d_s1, d_s2;
  logic          pclk_rise, vs_rise, vs_fall, href_rise, href_fall;
  logic          active, byte_stb, cur_phase, pix_done, pix_ovf;
  logic          start_frame, end_frame;
  logic          phase_q, vs_pend_q;
  logic [7:0]    hi_q;
  logic [CW-1:0] addr_q;
  logic [LW-1:0] line_cnt_q;

  // Synchronizers: s1 = [0], s2 = [1], s3 = [2] (edge-detect stage).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s  <= '0;
      vsync_s <= '0;
      href_s  <= '0;
      d_s1    <= '0;
      d_s2    <= '0;
    end else begin
      pclk_s  <= {pclk_s[1:0], cam_pclk};
      vsync_s <= {vsync_s[1:0], cam_vsync};
      href_s  <= {href_s[1:0], cam_href};
      d_s1    <= cam_d;
      d_s2    <= d_s1;
    end
  end

  assign pclk_rise = pclk_s[1] & ~pclk_s[2];
  assign vs_rise   = vsync_s[1] & ~vsync_s[2];
  assign vs_fall   = ~vsync_s[1] & vsync_s[2];
  assign href_rise = href_s[1] & ~href_s[2];
  assign href_fall = ~href_s[1] & href_s[2];

  assign active    = (state_q == ACTIVE);
  assign byte_stb  = active & pclk_rise & href_s[1];
  // A line start re-aligns the pairing even if a byte lands in the same cycle.
  assign cur_phase = href_rise ? 1'b0 : phase_q;
  assign pix_done  = byte_stb & cur_phase;
  assign pix_ovf   = pix_done & (addr_q == CAP[CW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_CFG;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      WAIT_CFG: if (cfg_done) state_d = SYNC;
      SYNC: begin
        if (vs_fall && capture_en) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        // A pixel completing with the vsync rise defers the exit by one cycle
        // so its write strobe precedes frame_done.
        if ((vs_rise && !pix_done) || vs_pend_q) begin
          state_d   = SYNC;
          end_frame = 1'b1;
        end
      end
      default: state_d = WAIT_CFG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_pend_q   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      addr_q      <= '0;
      ovf_err     <= 1'b0;
      line_err    <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      line_cnt_q  <= '0;
    end else begin
      vs_pend_q   <= active & vs_rise & pix_done;
      frame_start <= start_frame;
      frame_done  <= end_frame;
      if (end_frame) frame_cnt <= frame_cnt + 16'd1;

      wr_en <= pix_done & ~pix_ovf;
      if (pix_done && !pix_ovf) wr_data <= {hi_q, d_s2};

      if (start_frame)  addr_q <= '0;
      else if (wr_en)   addr_q <= addr_q + 1'b1;

      if (start_frame)  ovf_err <= 1'b0;
      else if (pix_ovf) ovf_err <= 1'b1;

      if (start_frame) line_err <= 1'b0;
      else if (active && href_fall && line_cnt_q != H_PIXELS[LW-1:0]) line_err <= 1'b1;

      if (start_frame)               phase_q <= 1'b0;
      else if (byte_stb)             phase_q <= ~cur_phase;
      else if (active && href_rise)  phase_q <= 1'b0;

      if (byte_stb && !cur_phase) hi_q <= d_s2;

      // Saturating so a runaway line cannot wrap back to a legal count.
      if (start_frame || (active && href_rise)) line_cnt_q <= '0;
      else if (pix_done && line_cnt_q != '1)    line_cnt_q <= line_cnt_q + 1'b1;
    end
  end

  assign wr_addr = addr_q[ADDR_W-1:0];
  assign busy    = active;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: drives synthetic OV7670 frames and checks the write stream.
module tb_ov7670_capture;
  localparam int HP = 4, VL = 2, AW = 4, CAP = HP * VL;

  logic          clk = 0, rst = 1, cfg_done = 0, capture_en = 1;
  logic          cam_pclk = 0, cam_vsync = 1, cam_href = 0;
  logic [7:0]    cam_d = 0;
  logic          wr_en, frame_start, frame_done, busy, line_err, ovf_err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data, frame_cnt;

  ov7670_capture #(.H_PIXELS(HP), .V_LINES(VL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_done(cfg_done), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .busy(busy), .line_err(line_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  initial begin #3; forever #40 cam_pclk = ~cam_pclk; end

  int n_vec = 0, n_err = 0;
  int cyc = 0, fs_n = 0, fd_n = 0, fs_cyc = 0, fd_cyc = 0, lerr_cyc = -1;
  bit busy_seen = 0;
  logic [AW-1:0] got_addr[$];
  logic [15:0]   got_data[$];
  int            got_cyc[$];
  logic [15:0]   exp_data[$];
  logic [15:0]   exp_fcnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin got_addr.push_back(wr_addr); got_data.push_back(wr_data); got_cyc.push_back(cyc); end
    if (frame_start) begin fs_n++; fs_cyc = cyc; end
    if (frame_done)  begin fd_n++; fd_cyc = cyc; end
    if (line_err && lerr_cyc < 0) lerr_cyc = cyc;
    if (busy) busy_seen = 1;
  end

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] kk;
    kk = k[7:0];
    return 8'h12 + 8'h22 * kk;
  endfunction

  task automatic clear_mon();
    got_addr.delete(); got_data.delete(); got_cyc.delete(); exp_data.delete();
    fs_n = 0; fd_n = 0; lerr_cyc = -1; busy_seen = 0;
  endtask

  // Line 0 carries nb0 bytes, later lines nbn; expected pixels are built from the byte stream.
  task automatic drive_frame(input int nl, input int nb0, input int nbn, input bit cap);
    int k, np, nb;
    logic [7:0] hi, b;
    k = 0; np = 0; hi = 0;
    cam_vsync = 1; repeat (4) @(negedge cam_pclk);
    cam_vsync = 0; repeat (4) @(negedge cam_pclk);
    for (int l = 0; l < nl; l++) begin
      nb = (l == 0) ? nb0 : nbn;
      cam_href = 1;
      for (int i = 0; i < nb; i++) begin
        b = byte_at(k); k++; cam_d = b;
        if (i % 2 == 0) hi = b;
        else if (cap && np < CAP) begin exp_data.push_back({hi, b}); np++; end
        @(negedge cam_pclk);
      end
      cam_href = 0; repeat (4) @(negedge cam_pclk);
    end
    cam_vsync = 1; repeat (4) @(negedge cam_pclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if ({wr_en, frame_start, frame_done, busy, line_err, ovf_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 000000", {wr_en, frame_start, frame_done, busy, line_err, ovf_err}); end
    n_vec++; if (wr_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", wr_addr); end
    n_vec++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_data: got %0h want 0", wr_data); end
    n_vec++; if (frame_cnt !== '0) begin n_err++; $display("FAIL reset_fcnt: got %0h want 0", frame_cnt); end
    rst = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_cfg();
    clear_mon();
    drive_frame(2, 8, 8, 0);
    n_vec++; if (got_addr.size() != 0) begin n_err++; $display("FAIL nocfg_writes: got %0d want 0", got_addr.size()); end
    n_vec++; if (fs_n != 0) begin n_err++; $display("FAIL nocfg_fstart: got %0d want 0", fs_n); end
    n_vec++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL nocfg_busy: got %b want 0", busy_seen); end
    cfg_done = 1;
    clear_mon();
    drive_frame(2, 8, 8, 1);
    exp_fcnt++;
    n_vec++; if (got_addr.size() != 8) begin n_err++; $display("FAIL cfg_writes: got %0d want 8", got_addr.size()); end
    n_vec++; if (fs_n != 1) begin n_err++; $display("FAIL cfg_fstart: got %0d want 1", fs_n); end
    n_vec++; if (frame_cnt !== exp_fcnt) begin n_err++; $display("FAIL cfg_fcnt: got %0d want %0d", frame_cnt, exp_fcnt); end
  endtask

  task automatic test_normal();
    clear_mon();
    drive_frame(2, 8, 8, 1);
    exp_fcnt++;
    n_vec++; if (got_addr.size() != 8) begin n_err++; $display("FAIL norm_count: got %0d want 8", got_addr.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++; if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
          n_err++; $display("FAIL norm_pix%0d: got %0h/%0h want %0h/%0h", i, got_addr[i], got_data[i], i, exp_data[i]); end
      end
      n_vec++; if (got_data[0] !== 16'h1234) begin n_err++; $display("FAIL norm_first: got %0h want 1234", got_data[0]); end
      n_vec++; if (!(fs_cyc < got_cyc[0])) begin n_err++; $display("FAIL norm_fs_order: got cyc %0d want < %0d", fs_cyc, got_cyc[0]); end
      n_vec++; if (!(fd_cyc > got_cyc[7])) begin n_err++; $display("FAIL norm_fd_order: got cyc %0d want > %0d", fd_cyc, got_cyc[7]); end
    end
    n_vec++; if (fd_n != 1) begin n_err++; $display("FAIL norm_fdone: got %0d want 1", fd_n); end
    n_vec++; if (frame_cnt !== exp_fcnt) begin n_err++; $display("FAIL norm_fcnt: got %0d want %0d", frame_cnt, exp_fcnt); end
    n_vec++; if ({line_err, ovf_err, busy} !== 3'b000) begin n_err++; $display("FAIL norm_flags: got %b want 000", {line_err, ovf_err, busy}); end
    n_vec++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL norm_busy_seen: got %b want 1", busy_seen); end
  endtask

  task automatic test_short_line();
    clear_mon();
    drive_frame(2, 6, 8, 1);
    exp_fcnt++;
    n_vec++; if (got_addr.size() != 7) begin n_err++; $display("FAIL short_count: got %0d want 7", got_addr.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        n_vec++; if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
          n_err++; $display("FAIL short_pix%0d: got %0h/%0h want %0h/%0h", i, got_addr[i], got_data[i], i, exp_data[i]); end
      end
      n_vec++; if (!(lerr_cyc > got_cyc[2] && lerr_cyc < got_cyc[3])) begin
        n_err++; $display("FAIL short_lerr_time: got cyc %0d want in (%0d,%0d)", lerr_cyc, got_cyc[2], got_cyc[3]); end
    end
    n_vec++; if (line_err !== 1'b1) begin n_err++; $display("FAIL short_lerr: got %b want 1", line_err); end
  endtask

  task automatic test_long_line();
    clear_mon();
    drive_frame(2, 9, 8, 1);
    exp_fcnt++;
    n_vec++; if (got_addr.size() != 8) begin n_err++; $display("FAIL long_count: got %0d want 8", got_addr.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++; if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
          n_err++; $display("FAIL long_pix%0d: got %0h/%0h want %0h/%0h", i, got_addr[i], got_data[i], i, exp_data[i]); end
      end
      n_vec++; if (got_data[4] !== 16'h4466) begin n_err++; $display("FAIL long_line1_first: got %0h want 4466", got_data[4]); end
    end
    n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL long_lerr: got %b want 0", line_err); end
  endtask

  task automatic test_overflow();
    clear_mon();
    drive_frame(3, 8, 8, 1);
    exp_fcnt++;
    n_vec++; if (got_addr.size() != 8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", got_addr.size()); end
    else if (got_addr[7] !== 4'd7) begin n_vec++; n_err++; $display("FAIL ovf_last_addr: got %0h want 7", got_addr[7]); end
    n_vec++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
    n_vec++; if (wr_addr !== 4'd8) begin n_err++; $display("FAIL ovf_addr_hold: got %0d want 8", wr_addr); end
    n_vec++; if (fd_n != 1) begin n_err++; $display("FAIL ovf_fdone: got %0d want 1", fd_n); end
    n_vec++; if (frame_cnt !== exp_fcnt) begin n_err++; $display("FAIL ovf_fcnt: got %0d want %0d", frame_cnt, exp_fcnt); end
  endtask

  task automatic test_skip_and_reset();
    int n_at_rst;
    bit hit;
    capture_en = 0;
    clear_mon();
    drive_frame(2, 8, 8, 0);
    n_vec++; if (got_addr.size() != 0 || fs_n != 0 || fd_n != 0) begin
      n_err++; $display("FAIL skip_activity: got %0d/%0d/%0d want 0/0/0", got_addr.size(), fs_n, fd_n); end
    n_vec++; if (frame_cnt !== exp_fcnt) begin n_err++; $display("FAIL skip_fcnt: got %0d want %0d", frame_cnt, exp_fcnt); end
    capture_en = 1;
    clear_mon();
    n_at_rst = 0;
    fork
      drive_frame(2, 8, 8, 0);
      begin
        hit = 0;
        for (int c = 0; c < 2000 && !hit; c++) begin
          @(posedge clk);
          if (got_addr.size() >= 2) hit = 1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL rst_wait: got %0d writes want 2", got_addr.size()); end
        #2 rst = 1; n_at_rst = got_addr.size();
        #1;
        exp_fcnt = 0;
        n_vec++; if ({wr_en, busy, frame_start, frame_done, line_err, ovf_err} !== 6'b0) begin
          n_err++; $display("FAIL rst_mid_flags: got %b want 000000", {wr_en, busy, frame_start, frame_done, line_err, ovf_err}); end
        n_vec++; if (wr_addr !== '0 || frame_cnt !== '0) begin
          n_err++; $display("FAIL rst_mid_regs: got %0h/%0h want 0/0", wr_addr, frame_cnt); end
        cfg_done = 0;
        repeat (3) @(negedge clk);
        rst = 0;
      end
    join
    n_vec++; if (got_addr.size() != n_at_rst) begin n_err++; $display("FAIL rst_tail_writes: got %0d want %0d", got_addr.size(), n_at_rst); end
    clear_mon();
    drive_frame(2, 8, 8, 0);
    n_vec++; if (got_addr.size() != 0 || busy_seen) begin
      n_err++; $display("FAIL rst_waitcfg: got %0d writes busy %b want 0/0", got_addr.size(), busy_seen); end
    cfg_done = 1;
    clear_mon();
    drive_frame(2, 8, 8, 1);
    exp_fcnt++;
    n_vec++; if (got_addr.size() != 8) begin n_err++; $display("FAIL rst_recover: got %0d want 8", got_addr.size()); end
    n_vec++; if (frame_cnt !== exp_fcnt) begin n_err++; $display("FAIL rst_recover_fcnt: got %0d want %0d", frame_cnt, exp_fcnt); end
  endtask

  initial begin
    test_reset();
    test_no_cfg();
    test_normal();
    test_short_line();
    test_long_line();
    test_overflow();
    test_skip_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
